// File: rtl/control_pkg.sv
// Shared constants, FSM state type and row-count helper for the CSR
// sparse matrix-vector controller.
package control_pkg;

  localparam int N_ROWS  = 16;
  localparam int COL_OFS = 17;

  localparam logic [4:0] REG_COL_BASE = 5'd6;
  localparam logic [4:0] REG_ROW_BASE = 5'd15;
  localparam logic [4:0] REG_V_BASE   = 5'd8;
  localparam logic [4:0] REG_MAT_BASE = 5'd9;

  typedef enum logic [3:0] {
    IDLE, BASE1, BASE2, PTR0, PTR, ELEM_A, ELEM_B, POST, DONE
  } state_t;

  // Nonzero count of a row, clamped to the 5-bit adata field.
  function automatic logic [4:0] sat_count(input logic [31:0] first,
                                           input logic [31:0] last);
    logic [31:0] diff;
    diff = last - first;
    if (last <= first) return 5'd0;
    return (diff > 32'd31) ? 5'd31 : diff[4:0];
  endfunction

endpackage

// File: rtl/control_if.sv
// Multiply-accumulate bus between the control FSM (master) and control_mac.
interface control_if;
  logic        clear;
  logic        en;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] acc;
  logic [31:0] nxt;

  modport master (output clear, en, a, b, input acc, nxt);
  modport slave  (input clear, en, a, b, output acc, nxt);
endinterface

// File: rtl/control_mac.sv
// 32-bit multiply-accumulate; wraps mod 2^32 by default, saturates at
// 32'hFFFFFFFF when CONTROL_SAT_EN is defined.
module control_mac (
  input logic       clk,
  input logic       rst_n,
  control_if.slave  mac
);

`ifdef CONTROL_SAT_EN
  logic [63:0] prod_full;
  logic [32:0] sum_full;
  logic [31:0] prod;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    prod      = '0;
    prod_full = 64'(mac.a) * 64'(mac.b);
    prod      = (|prod_full[63:32]) ? 32'hFFFF_FFFF : prod_full[31:0];
    sum_full  = 33'(mac.acc) + 33'(prod);
    mac.nxt   = sum_full[32] ? 32'hFFFF_FFFF : sum_full[31:0];
  end
`else
  always_comb begin
    mac.nxt = '0;
    mac.nxt = mac.acc + (mac.a * mac.b);
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        mac.acc <= '0;
    else if (mac.clear) mac.acc <= '0;
    else if (mac.en)    mac.acc <= mac.nxt;
  end

endmodule

// File: rtl/control.sv
// CSR sparse matrix (16x16) times vector controller; one hht strobe per row.
// Optional CONTROL_SAT_EN makes the accumulation saturating (see control_mac).
module control
  import control_pkg::*;
(
  input  logic        Clk,
  input  logic [31:0] base_dat_a,
  input  logic [31:0] base_dat_b,
  output logic [31:0] addr1,
  output logic [31:0] addr2,
  input  logic [31:0] dataIn1,
  input  logic [31:0] dataIn2,
  input  logic        Rst,
  input  logic        RD,
  input  logic [31:0] csize,
  input  logic [31:0] cpu_addr,
  output logic        hht,
  output logic [4:0]  regaddr1,
  output logic [4:0]  regaddr2,
  output logic [4:0]  rdata,
  output logic [4:0]  adata,
  output logic [31:0] y_data,
  output logic [31:0] y_addr
);

  localparam logic [4:0] LAST_ROW = 5'(N_ROWS - 1);

  state_t      state;
  logic [4:0]  row;
  logic [31:0] k, start_ptr, end_ptr, val;
  logic [31:0] col_base, row_base, v_base, mat_base;
  logic [31:0] end_now, k_inc;

  control_if mac_bus ();

  control_mac u_mac (
    .clk   (Clk),
    .rst_n (Rst),
    .mac   (mac_bus)
  );

  assign mac_bus.clear = RD && (state == PTR);
  assign mac_bus.en    = RD && (state == ELEM_B);
  assign mac_bus.a     = val;
  assign mac_bus.b     = dataIn2;

  assign end_now = (dataIn1 < csize) ? dataIn1 : csize;
  assign k_inc   = k + 32'd1;

  // Addresses are registered one state ahead so that the combinational
  // memory answers during the state that consumes the data.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      row       <= '0;
      k         <= '0;
      start_ptr <= '0;
      end_ptr   <= '0;
      val       <= '0;
      col_base  <= '0;
      row_base  <= '0;
      v_base    <= '0;
      mat_base  <= '0;
      addr1     <= '0;
      addr2     <= '0;
      regaddr1  <= '0;
      regaddr2  <= '0;
      hht       <= 1'b0;
      rdata     <= '0;
      adata     <= '0;
      y_data    <= '0;
      y_addr    <= '0;
    end else if (RD) begin
      case (state)
        IDLE: begin
          regaddr1 <= REG_COL_BASE;
          regaddr2 <= REG_ROW_BASE;
          state    <= BASE1;
        end
        BASE1: begin
          col_base <= base_dat_a;
          row_base <= base_dat_b;
          regaddr1 <= REG_V_BASE;
          regaddr2 <= REG_MAT_BASE;
          state    <= BASE2;
        end
        BASE2: begin
          v_base   <= base_dat_a;
          mat_base <= base_dat_b;
          regaddr1 <= '0;
          regaddr2 <= '0;
          addr1    <= row_base;
          state    <= PTR0;
        end
        PTR0: begin
          start_ptr <= dataIn1;
          addr1     <= row_base + 32'(row) + 32'd1;
          state     <= PTR;
        end
        PTR: begin
          end_ptr <= end_now;
          k       <= start_ptr;
          if (start_ptr >= end_now) begin
            addr1  <= '0;
            hht    <= 1'b1;
            rdata  <= row;
            adata  <= sat_count(start_ptr, end_now);
            y_data <= '0;
            y_addr <= cpu_addr + 32'(row);
            state  <= POST;
          end else begin
            addr1 <= col_base + 32'(COL_OFS) + start_ptr;
            addr2 <= mat_base + start_ptr;
            state <= ELEM_A;
          end
        end
        ELEM_A: begin
          // The column index goes straight into the vector address.
          val   <= dataIn2;
          addr1 <= '0;
          addr2 <= v_base + 32'(dataIn1[3:0]);
          state <= ELEM_B;
        end
        ELEM_B: begin
          k <= k_inc;
          if (k_inc < end_ptr) begin
            addr1 <= col_base + 32'(COL_OFS) + k_inc;
            addr2 <= mat_base + k_inc;
            state <= ELEM_A;
          end else begin
            addr2  <= '0;
            hht    <= 1'b1;
            rdata  <= row;
            adata  <= sat_count(start_ptr, end_ptr);
            y_data <= mac_bus.nxt;
            y_addr <= cpu_addr + 32'(row);
            state  <= POST;
          end
        end
        POST: begin
          hht       <= 1'b0;
          start_ptr <= end_ptr;
          if (row == LAST_ROW) begin
            addr1 <= '0;
            state <= DONE;
          end else begin
            row   <= row + 5'd1;
            addr1 <= row_base + 32'(row) + 32'd2;
            state <= PTR;
          end
        end
        DONE: begin
          addr1    <= '0;
          addr2    <= '0;
          regaddr1 <= '0;
          regaddr2 <= '0;
          hht      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_control.sv
// Directed testbench for control: CSR memory model, per-row result checks,
// RD freeze, empty row, mid-row reset and a standalone MAC check.
module tb_control;

  localparam logic [31:0] ROW_BASE = 32'd25940;
  localparam logic [31:0] COL_BASE = 32'd2440;
  localparam logic [31:0] MAT_BASE = 32'd90;
  localparam logic [31:0] V_BASE   = 32'd2;
  localparam logic [31:0] CSIZE    = 32'd154;
  localparam logic [31:0] CPU_ADDR = 32'd126;
  localparam logic [31:0] RP [17] = '{0, 12, 20, 34, 42, 42, 50, 60, 70, 80,
                                      90, 95, 100, 105, 110, 150, 200};

  logic        Clk, Rst, RD, hht;
  logic [31:0] base_dat_a, base_dat_b, addr1, addr2, dataIn1, dataIn2;
  logic [31:0] csize, cpu_addr, y_data, y_addr;
  logic [4:0]  regaddr1, regaddr2, rdata, adata;

  int checks   = 0;
  int failures = 0;

  control dut (
    .Clk(Clk), .base_dat_a(base_dat_a), .base_dat_b(base_dat_b),
    .addr1(addr1), .addr2(addr2), .dataIn1(dataIn1), .dataIn2(dataIn2),
    .Rst(Rst), .RD(RD), .csize(csize), .cpu_addr(cpu_addr), .hht(hht),
    .regaddr1(regaddr1), .regaddr2(regaddr2), .rdata(rdata), .adata(adata),
    .y_data(y_data), .y_addr(y_addr)
  );

  control_if mbus ();
  control_mac u_mac (.clk(Clk), .rst_n(Rst), .mac(mbus));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] val_of(input logic [31:0] k);
    if (k == 32'd0)   return 32'd27755;
    if (k == 32'd35)  return 32'd6615;
    if (k == 32'd100) return 32'hFFFF_FFF0;
    return 32'd100;
  endfunction

  function automatic logic [31:0] clamp(input logic [31:0] p);
    return (p < CSIZE) ? p : CSIZE;
  endfunction

  function automatic logic [31:0] expected_y(input int r);
    logic [31:0] acc;
    acc = '0;
    for (logic [31:0] k = clamp(RP[r]); k < clamp(RP[r+1]); k++)
      acc = acc + val_of(k) * ((k % 32'd16) + 32'd1);
    return acc;
  endfunction

  function automatic logic [31:0] expected_adata(input int r);
    logic [31:0] s, e;
    s = clamp(RP[r]);
    e = clamp(RP[r+1]);
    if (e <= s) return 32'd0;
    return (e - s > 32'd31) ? 32'd31 : e - s;
  endfunction

  // Combinational memories and base-register file.
  always_comb begin
    logic [31:0] off;
    base_dat_a = (regaddr1 == 5'd6) ? COL_BASE : (regaddr1 == 5'd8) ? V_BASE : 32'd0;
    base_dat_b = (regaddr2 == 5'd15) ? ROW_BASE : (regaddr2 == 5'd9) ? MAT_BASE : 32'd0;
    dataIn1 = 32'hDEAD_BEEF;
    dataIn2 = 32'd0;
    off = '0;
    if (addr1 >= ROW_BASE && addr1 <= ROW_BASE + 32'd16) begin
      off = addr1 - ROW_BASE;
      dataIn1 = RP[off[4:0]];
    end else if (addr1 >= COL_BASE + 32'd17 && addr1 < COL_BASE + 32'd273) begin
      off = addr1 - COL_BASE - 32'd17;
      dataIn1 = {28'hABCDEF0, off[3:0]};
    end
    if (addr2 >= MAT_BASE && addr2 < MAT_BASE + 32'd256)
      dataIn2 = val_of(addr2 - MAT_BASE);
    else if (addr2 >= V_BASE && addr2 < V_BASE + 32'd16)
      dataIn2 = addr2 - V_BASE + 32'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_hht(output int n);
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (hht !== 1'b1 && n < 400);
    check("hht_arrives", 32'(hht), 32'd1);
  endtask

  initial begin
    int n;
    int pulses;
    int hht_seen;
    Rst = 1'b0; RD = 1'b0; csize = CSIZE; cpu_addr = CPU_ADDR;
    mbus.clear = 1'b0; mbus.en = 1'b0; mbus.a = '0; mbus.b = '0;
    repeat (3) @(negedge Clk);
    check("rst_hht", 32'(hht), 32'd0);
    check("rst_addr1", addr1, 32'd0);
    check("rst_regaddr1", 32'(regaddr1), 32'd0);
    check("rst_y_data", y_data, 32'd0);

    Rst = 1'b1;
    repeat (2) @(negedge Clk);
    check("idle_wait_rd", 32'(regaddr1), 32'd0);
    RD = 1'b1;
    @(negedge Clk);
    check("base1_reg1", 32'(regaddr1), 32'd6);
    check("base1_reg2", 32'(regaddr2), 32'd15);
    @(negedge Clk);
    check("base2_reg1", 32'(regaddr1), 32'd8);
    check("base2_reg2", 32'(regaddr2), 32'd9);
    @(negedge Clk);
    check("ptr0_addr1", addr1, ROW_BASE);
    check("ptr0_regaddr1", 32'(regaddr1), 32'd0);
    @(negedge Clk);
    check("ptr_addr1", addr1, ROW_BASE + 32'd1);

    pulses = 0;
    for (int r = 0; r < 16; r++) begin
      wait_hht(n);
      if (hht === 1'b1) pulses++;
      check($sformatf("row%0d_rdata", r), 32'(rdata), 32'(r));
      check($sformatf("row%0d_adata", r), 32'(adata), expected_adata(r));
      check($sformatf("row%0d_y_data", r), y_data, expected_y(r));
      check($sformatf("row%0d_y_addr", r), y_addr, CPU_ADDR + 32'(r));
      case (r)
        0: begin
          check("row0_y_const", y_data, 32'd35455);
          check("row0_latency", 32'(n), 32'd25);
        end
        3: begin
          check("row3_y_const", y_data, 32'd31260);
          check("row3_adata_const", 32'(adata), 32'd8);
          check("row3_y_addr_const", y_addr, 32'd129);
        end
        4: begin
          check("row4_empty_latency", 32'(n), 32'd2);
          check("row4_y_zero", y_data, 32'd0);
          check("row4_adata_zero", 32'(adata), 32'd0);
        end
        5: begin
          @(negedge Clk);
          check("row6_ptr_addr1", addr1, ROW_BASE + 32'd7);
          @(negedge Clk);
          check("row6_elem_addr1", addr1, 32'd2507);
          check("row6_elem_addr2", addr2, 32'd140);
          RD = 1'b0;
          for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check("freeze_addr1", addr1, 32'd2507);
            check("freeze_addr2", addr2, 32'd140);
            check("freeze_hht", 32'(hht), 32'd0);
          end
          RD = 1'b1;
        end
        12: check("row12_wrap_y", y_data, 32'd2920);
        14: check("row14_adata_sat", 32'(adata), 32'd31);
        15: begin
          check("row15_clamp_adata", 32'(adata), 32'd4);
          check("row15_y_const", y_data, 32'd3400);
        end
        default: ;
      endcase
    end
    check("hht_pulse_count", 32'(pulses), 32'd16);

    hht_seen = 0;
    repeat (10) begin
      @(negedge Clk);
      if (hht !== 1'b0) hht_seen++;
    end
    check("done_no_hht", 32'(hht_seen), 32'd0);
    check("done_addr1", addr1, 32'd0);
    check("done_addr2", addr2, 32'd0);
    check("done_regaddr2", 32'(regaddr2), 32'd0);

    Rst = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    repeat (10) @(negedge Clk);
    #2 Rst = 1'b0;
    #1;
    check("midrst_addr1", addr1, 32'd0);
    check("midrst_addr2", addr2, 32'd0);
    check("midrst_y_data", y_data, 32'd0);
    check("midrst_hht", 32'(hht), 32'd0);
    RD = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    check("midrst_hold_rd", 32'(regaddr1), 32'd0);
    RD = 1'b1;
    @(negedge Clk);
    check("restart_reg1", 32'(regaddr1), 32'd6);
    check("restart_reg2", 32'(regaddr2), 32'd15);
    wait_hht(n);
    check("restart_rdata", 32'(rdata), 32'd0);
    check("restart_y_data", y_data, 32'd35455);

    mbus.clear = 1'b1;
    @(negedge Clk);
    check("mac_clear", mbus.acc, 32'd0);
    mbus.clear = 1'b0; mbus.en = 1'b1; mbus.a = 32'd3; mbus.b = 32'd5;
    #1 check("mac_nxt", mbus.nxt, 32'd15);
    @(negedge Clk);
    check("mac_acc", mbus.acc, 32'd15);
    mbus.a = 32'hFFFF_FFFF; mbus.b = 32'd2;
    @(negedge Clk);
    check("mac_wrap", mbus.acc, 32'd13);
    mbus.en = 1'b0; mbus.a = 32'd7;
    @(negedge Clk);
    check("mac_hold", mbus.acc, 32'd13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control.md
CONTROL -- requirements
Module: control

Interface
- REQ-001 SHALL use port order Clk, base_dat_a, base_dat_b, addr1, addr2, dataIn1, dataIn2, Rst, RD, csize, cpu_addr, hht, regaddr1, regaddr2, rdata, adata, y_data, y_addr.
- REQ-002 Clk  in  1  sole clock, rising edge.
- REQ-003 Rst  in  1  reset, asynchronous, active-low.
- REQ-004 RD  in  1  run enable; low freezes all state and outputs.
- REQ-005 base_dat_a / base_dat_b  in  32  base values answering regaddr1 / regaddr2.
- REQ-006 dataIn1 / dataIn2  in  32  memory read data, combinational response to addr1 / addr2 in the same cycle.
- REQ-007 csize  in  32  nonzero-count bound (NNZ limit).
- REQ-008 cpu_addr  in  32  result destination base address.
- REQ-009 addr1 / addr2  out  32  read addresses for port 1 (row pointers, column indices) and port 2 (values, vector).
- REQ-010 regaddr1 / regaddr2  out  5  base-register selectors.
- REQ-011 hht  out  1  one-cycle row-result strobe; rdata  out  5  row index; adata  out  5  row nonzero count; y_data  out  32  row result; y_addr  out  32  cpu_addr+row. All valid while hht=1.

Function
- REQ-012 SHALL compute y = A*v for a 16x16 CSR matrix, row 0 to row 15, with 32-bit unsigned arithmetic; products truncated to 32 bits; accumulation wraps mod 2^32.
- REQ-013 FSM states: IDLE, BASE1, BASE2, PTR0, PTR, ELEM_A, ELEM_B, POST, DONE.
- REQ-014 IDLE->BASE1 on the first enabled cycle after reset.
- REQ-015 BASE1: regaddr1=6, regaddr2=15; latch col_base=base_dat_a and row_base=base_dat_b.
- REQ-016 BASE2: regaddr1=8, regaddr2=9; latch v_base=base_dat_a and mat_base=base_dat_b.
- REQ-017 PTR0: addr1=row_base; latch start=dataIn1.
- REQ-018 PTR: addr1=row_base+r+1; latch end=min(dataIn1,csize); k=start; acc=0.
- REQ-019 PTR: if k>=end, go to POST (empty row, y=0); otherwise go to ELEM_A.
- REQ-020 ELEM_A: addr1=col_base+17+k; addr2=mat_base+k; latch col=dataIn1[3:0] and val=dataIn2.
- REQ-021 ELEM_B: addr2=v_base+col; acc+=val*dataIn2; k++.
- REQ-022 ELEM_B: go to ELEM_A while k<end, else go to POST.
- REQ-023 POST: hht=1 for exactly one cycle; rdata=r; adata=end-start (saturating at 31); y_data=acc; y_addr=cpu_addr+r.
- REQ-024 After POST, start=end, r++, and the FSM returns to PTR; after row 15 it goes to DONE.
- REQ-025 DONE is terminal until reset: hht=0; addresses and selectors at 0.
- REQ-026 Outside active states, addr1, addr2, regaddr1 and regaddr2 SHALL be 0.
- REQ-027 RD low mid-row freezes state and outputs; resuming continues with no lost or duplicated element.

Reset
- REQ-028 Rst low forces IDLE; r, k, acc, all latched bases and all outputs go to 0 immediately.
- REQ-029 Rst asserted mid-operation abandons the computation; after release, restart from BASE1.

Configuration
- REQ-030 CONTROL_SAT_EN defined: accumulator and products saturate at 32'hFFFFFFFF.
- REQ-031 CONTROL_SAT_EN undefined: arithmetic wraps per REQ-012.

Structure
- REQ-032 Package control_pkg SHALL hold N_ROWS=16, COL_OFS=17, register ids (6, 8, 15, 9) and the FSM state enum.
- REQ-033 A single sub-module control_mac SHALL implement multiply-accumulate, with saturation under CONTROL_SAT_EN.

Verification
Common setup: row_base=25940, col_base=2440, mat_base=90, v_base=2, csize=154, cpu_addr=126, RD=1.
- REQ-034 Setup above; row 0 ptrs 0/12 -> first hht with rdata=0, adata=12, y_data=35455, y_addr=126.
- REQ-035 Same setup; row 3 ptrs 34/42 -> hht with rdata=3, adata=8, y_data=31260, y_addr=129.
- REQ-036 Set rowptr[r]=rowptr[r+1] -> hht with adata=0, y_data=0, and no ELEM cycles for that row.
- REQ-037 Toggle RD low for 5 cycles mid-row -> outputs frozen; y_data identical to an uninterrupted run.
- REQ-038 Rst low mid-row -> outputs 0 at once; after release, regaddr1=6 and regaddr2=15 on the first enabled cycle.
- REQ-039 Full run -> exactly 16 hht pulses with rdata 0..15, then DONE with hht held at 0.
